// File: rtl/i2c_arb_pkg.sv
// ---------------------------------------------------------------------------
// i2c_arb_pkg
// Shared types and helpers for the I2C configuration arbiter.
//   arbState_t  : arbiter FSM states
//   I2C_WORD_W  : width of one controller transfer word
//   *_MSB/*_LSB : field positions inside a transfer word
//   rrNext()    : round-robin winner search starting after the last grant
// ---------------------------------------------------------------------------
package i2c_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT_END,
      ST_GAP,
      ST_DONE
   } arbState_t;

   localparam int unsigned I2C_WORD_W = 24;
   localparam int unsigned SLAVE_MSB  = 23;
   localparam int unsigned SLAVE_LSB  = 16;
   localparam int unsigned SUB_MSB    = 15;
   localparam int unsigned SUB_LSB    = 8;
   localparam int unsigned DATA_MSB   = 7;
   localparam int unsigned DATA_LSB   = 0;

   // Scans last+1, last+2, ... (mod n) and returns the first pending index.
   // Returns last unchanged when nothing is pending; callers gate on |req.
   function automatic logic [2:0] rrNext(input logic [7:0]  req,
                                         input logic [2:0]  last,
                                         input int unsigned n);
      logic [2:0]  pick;
      logic        found;
      int unsigned idx;
      pick  = last;
      found = 1'b0;
      for (int unsigned i = 1; i <= 8; i++) begin
         if (i <= n) begin
            idx = {29'b0, last} + i;
            if (idx >= n) idx = idx - n;
            if (!found && req[idx[2:0]]) begin
               pick  = idx[2:0];
               found = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// ---------------------------------------------------------------------------
// i2c_tick_gen
// Divides iCLK down to the I2C controller work clock and flags the iCLK
// cycle in which that clock is about to rise (the "tick").
//   iCLK    : system clock
//   iRST_N  : asynchronous active-low reset
//   oCLK    : controller work clock, half period CLK_FREQ/(2*I2C_FREQ) cycles
//   oTICK   : high for the one iCLK cycle whose edge drives oCLK 0->1
// ---------------------------------------------------------------------------
module i2c_tick_gen #(
   parameter int unsigned CLK_FREQ = 50000000,
   parameter int unsigned I2C_FREQ = 20000
) (
   input  logic iCLK,
   input  logic iRST_N,
   output logic oCLK,
   output logic oTICK
);

   localparam int unsigned HALF = CLK_FREQ / (2 * I2C_FREQ);
   localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] LAST = CW'(HALF - 1);

   logic [CW-1:0] cnt;
   logic          wrap;

   assign wrap  = (cnt == LAST);
   assign oTICK = wrap & ~oCLK;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         cnt  <= '0;
         oCLK <= 1'b0;
      end else if (wrap) begin
         cnt  <= '0;
         oCLK <= ~oCLK;
      end else begin
         cnt  <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/i2c_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_cfg_arbiter
// Shares one I2C_Controller between N_REQ configuration requesters with
// round-robin arbitration, NACK/timeout retry and per-requester completion.
//   iCLK, iRST_N   : system clock, asynchronous active-low reset
//   iREQ           : per-requester pending flag, held until its oDONE
//   iREQ_DATA      : slice i = {slave_addr, sub_addr, data}
//   oGNT           : one-hot owner of the controller
//   oDONE / oERR   : one-cycle completion pulse, oERR = retries exhausted
//   oBUSY          : transfer in progress
//   oI2C_CTRL_CLK  : controller work clock
//   oI2C_DATA      : latched transfer word to controller
//   oI2C_GO        : controller start
//   iI2C_END       : controller finished
//   iI2C_ACK       : 1 = slave NACKed
// ---------------------------------------------------------------------------
module i2c_cfg_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int unsigned N_REQ         = 2,
   parameter int unsigned CLK_FREQ      = 50000000,
   parameter int unsigned I2C_FREQ      = 20000,
   parameter int unsigned MAX_RETRY     = 3,
   parameter int unsigned TIMEOUT_TICKS = 64
) (
   input  logic                          iCLK,
   input  logic                          iRST_N,
   input  logic [N_REQ-1:0]              iREQ,
   input  logic [I2C_WORD_W*N_REQ-1:0]   iREQ_DATA,
   output logic [N_REQ-1:0]              oGNT,
   output logic [N_REQ-1:0]              oDONE,
   output logic [N_REQ-1:0]              oERR,
   output logic                          oBUSY,
   output logic                          oI2C_CTRL_CLK,
   output logic [I2C_WORD_W-1:0]         oI2C_DATA,
   output logic                          oI2C_GO,
   input  logic                          iI2C_END,
   input  logic                          iI2C_ACK
);

   localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);

   arbState_t             state, stateNext;
   logic [2:0]            winner, winnerNext;
   logic [2:0]            lastGnt, lastGntNext;
   logic [3:0]            retryCnt, retryNext;
   logic [TW-1:0]         timer, timerNext, timerInc;
   logic                  errFlag, errFlagNext;
   logic [I2C_WORD_W-1:0] dataNext;
   logic                  goNext, busyNext;
   logic [N_REQ-1:0]      gntNext, doneNext, errNext;
   logic [7:0]            reqPad;
   logic [2:0]            pick;
   logic                  tick;

   i2c_tick_gen #(
      .CLK_FREQ (CLK_FREQ),
      .I2C_FREQ (I2C_FREQ)
   ) uTickGen (
      .iCLK   (iCLK),
      .iRST_N (iRST_N),
      .oCLK   (oI2C_CTRL_CLK),
      .oTICK  (tick)
   );

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state     <= ST_IDLE;
         winner    <= '0;
         lastGnt   <= 3'(N_REQ - 1);
         retryCnt  <= '0;
         timer     <= '0;
         errFlag   <= 1'b0;
         oI2C_DATA <= '0;
         oI2C_GO   <= 1'b0;
         oGNT      <= '0;
         oBUSY     <= 1'b0;
         oDONE     <= '0;
         oERR      <= '0;
      end else begin
         state     <= stateNext;
         winner    <= winnerNext;
         lastGnt   <= lastGntNext;
         retryCnt  <= retryNext;
         timer     <= timerNext;
         errFlag   <= errFlagNext;
         oI2C_DATA <= dataNext;
         oI2C_GO   <= goNext;
         oGNT      <= gntNext;
         oBUSY     <= busyNext;
         oDONE     <= doneNext;
         oERR      <= errNext;
      end
   end

   always_comb begin
      stateNext   = state;
      winnerNext  = winner;
      lastGntNext = lastGnt;
      retryNext   = retryCnt;
      timerNext   = timer;
      errFlagNext = errFlag;
      dataNext    = oI2C_DATA;
      goNext      = oI2C_GO;
      gntNext     = oGNT;
      busyNext    = oBUSY;
      doneNext    = '0;
      errNext     = '0;
      reqPad      = '0;
      reqPad[N_REQ-1:0] = iREQ;
      pick        = rrNext(reqPad, lastGnt, N_REQ);
      timerInc    = timer + 1'b1;

      unique case (state)
         ST_IDLE: begin
            if (tick && (|iREQ)) begin
               winnerNext = pick;
               gntNext    = '0;
               for (int unsigned i = 0; i < N_REQ; i++) begin
                  if (pick == 3'(i)) begin
                     gntNext[i] = 1'b1;
                     dataNext   = iREQ_DATA[i*I2C_WORD_W +: I2C_WORD_W];
                  end
               end
               busyNext  = 1'b1;
               retryNext = '0;
               stateNext = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            if (tick) begin
               goNext    = 1'b1;
               timerNext = '0;
               stateNext = ST_WAIT_END;
            end
         end
         ST_WAIT_END: begin
            if (tick) begin
               timerNext = timerInc;
               // END is checked before the timeout so a late END still wins.
               if (iI2C_END && !iI2C_ACK) begin
                  goNext      = 1'b0;
                  errFlagNext = 1'b0;
                  stateNext   = ST_DONE;
               end else if (iI2C_END || (timerInc >= TW'(TIMEOUT_TICKS))) begin
                  goNext = 1'b0;
                  if (retryCnt < 4'(MAX_RETRY)) begin
                     retryNext = retryCnt + 1'b1;
                     stateNext = ST_GAP;
                  end else begin
                     errFlagNext = 1'b1;
                     stateNext   = ST_DONE;
                  end
               end
            end
         end
         ST_GAP: begin
            if (tick) stateNext = ST_LAUNCH;
         end
         ST_DONE: begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
               doneNext[i] = (winner == 3'(i));
            end
            errNext     = doneNext & {N_REQ{errFlag}};
            gntNext     = '0;
            busyNext    = 1'b0;
            lastGntNext = winner;
            stateNext   = ST_IDLE;
         end
         default: stateNext = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_i2c_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_cfg_arbiter
// Directed bench for i2c_cfg_arbiter with a transaction-level expectation
// model (round-robin owner, launches, error, GO width, completion latency)
// and a behavioural I2C controller responder.
// ---------------------------------------------------------------------------
module tb_i2c_cfg_arbiter;

   localparam int N    = 2;
   localparam int MAXR = 3;
   localparam int TMO  = 10;
   localparam int TICK = 8;   // iCLK cycles per controller clock period

   logic            iCLK = 1'b0;
   logic            iRST_N = 1'b0;
   logic [N-1:0]    iREQ = '0;
   logic [24*N-1:0] iREQ_DATA = '0;
   logic [N-1:0]    oGNT, oDONE, oERR;
   logic            oBUSY, oI2C_CTRL_CLK, oI2C_GO;
   logic [23:0]     oI2C_DATA;
   logic            iI2C_END = 1'b0;
   logic            iI2C_ACK = 1'b0;

   always #5 iCLK = ~iCLK;

   i2c_cfg_arbiter #(
      .N_REQ         (N),
      .CLK_FREQ      (8),
      .I2C_FREQ      (1),
      .MAX_RETRY     (MAXR),
      .TIMEOUT_TICKS (TMO)
   ) dut (
      .iCLK          (iCLK),
      .iRST_N        (iRST_N),
      .iREQ          (iREQ),
      .iREQ_DATA     (iREQ_DATA),
      .oGNT          (oGNT),
      .oDONE         (oDONE),
      .oERR          (oERR),
      .oBUSY         (oBUSY),
      .oI2C_CTRL_CLK (oI2C_CTRL_CLK),
      .oI2C_DATA     (oI2C_DATA),
      .oI2C_GO       (oI2C_GO),
      .iI2C_END      (iI2C_END),
      .iI2C_ACK      (iI2C_ACK)
   );

   int nCmp = 0;
   int nBad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Controller responder behaviour, set per scenario.
   int endAfter  = 5;    // ticks from GO to END
   int nackFirst = 0;    // launches of a transfer answered with NACK
   bit neverEnd  = 1'b0; // never raise END

   int   launchIdx = 0;
   int   tickCnt   = 0;
   logic goPrevM   = 1'b0;
   logic ctrlPrevM = 1'b0;

   initial begin
      forever begin
         @(posedge iCLK); #1;
         if (!iRST_N || !oI2C_GO) begin
            iI2C_END = 1'b0;
            iI2C_ACK = 1'b0;
            tickCnt  = 0;
         end
         if (!iRST_N || oGNT == '0) launchIdx = 0;
         if (iRST_N && oI2C_GO) begin
            if (!goPrevM) begin
               launchIdx++;
               tickCnt = 0;
            end else if (oI2C_CTRL_CLK && !ctrlPrevM) begin
               tickCnt++;
            end
            if (!neverEnd && !iI2C_END && tickCnt == endAfter - 1) begin
               iI2C_END = 1'b1;
               iI2C_ACK = (launchIdx <= nackFirst);
            end
         end
         goPrevM   = oI2C_GO;
         ctrlPrevM = oI2C_CTRL_CLK;
      end
   end

   // Expectation model state
   int          owner = -1;
   int          lastGntM = N - 1;
   int          cyc = 0;
   int          gntCyc, goFallCyc, firstGoCyc, lastRise;
   int          goPulses, goLen, expLaunch, expGoLen;
   bit          expErr;
   logic [23:0] ownData;
   logic        prevGo = 1'b0, prevCtrl = 1'b0, clkRose;
   logic [N-1:0] prevGnt = '0;
   int          doneCount = 0;
   int          doneWho[$];
   bit          doneErr[$];
   int          donePulses[$];
   int          doneLat[$];
   logic [23:0] doneData[$];

   function automatic int rrPredict(input logic [N-1:0] req, input int last);
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (last + k) % N;
         if (req[idx]) return idx;
      end
      return -1;
   endfunction

   always @(negedge iCLK) begin
      int w;
      int expMask;
      cyc++;
      if (!iRST_N) begin
         chk("rst_ctrl_outputs", {oI2C_GO, oBUSY, oGNT, oDONE, oERR, oI2C_CTRL_CLK}, 0);
         chk("rst_data", oI2C_DATA, 0);
         owner    = -1;
         lastGntM = N - 1;
         prevGo   = 1'b0;
         prevCtrl = 1'b0;
         prevGnt  = '0;
         lastRise = -1;
      end else begin
         clkRose = oI2C_CTRL_CLK && !prevCtrl;
         if (clkRose) begin
            if (lastRise >= 0) chk("ctrl_clk_period", cyc - lastRise, TICK);
            lastRise = cyc;
         end
         chk("busy_eq_gnt", oBUSY, |oGNT);

         if (prevGnt == '0 && oGNT != '0) begin
            w = rrPredict(iREQ, lastGntM);
            chk("grant_onehot", oGNT, (w < 0) ? 0 : (1 << w));
            chk("grant_at_tick", clkRose, 1);
            if (w >= 0) begin
               owner   = w;
               ownData = iREQ_DATA[w*24 +: 24];
            end
            gntCyc   = cyc;
            goPulses = 0;
            if (neverEnd) begin
               expLaunch = MAXR + 1; expErr = 1'b1; expGoLen = TMO;
            end else if (nackFirst > MAXR) begin
               expLaunch = MAXR + 1; expErr = 1'b1; expGoLen = endAfter;
            end else begin
               expLaunch = nackFirst + 1; expErr = 1'b0; expGoLen = endAfter;
            end
         end

         if (prevGo && clkRose) goLen++;
         if (!prevGo && oI2C_GO) begin
            chk("go_while_owned", owner >= 0, 1);
            if (goPulses == 0) begin
               chk("go_after_grant_cycles", cyc - gntCyc, TICK);
               firstGoCyc = cyc;
            end else begin
               chk("go_relaunch_gap_cycles", cyc - goFallCyc, 2 * TICK);
            end
            goPulses++;
            goLen = 0;
         end
         if (prevGo && !oI2C_GO) begin
            chk("go_len_ticks", goLen, expGoLen);
            goFallCyc = cyc;
         end

         if (owner >= 0 && oGNT != '0) chk("data_held", oI2C_DATA, ownData);

         if (oDONE != '0) begin
            expMask = (owner < 0) ? 0 : (1 << owner);
            chk("done_owner", oDONE, expMask);
            chk("done_err", oERR, expErr ? expMask : 0);
            chk("done_launches", goPulses, expLaunch);
            chk("done_after_go_fall", cyc - goFallCyc, 1);
            chk("done_latency", cyc - firstGoCyc,
                (expLaunch * expGoLen + 2 * (expLaunch - 1)) * TICK + 1);
            chk("done_gnt_cleared", oGNT, 0);
            chk("done_data", oI2C_DATA, ownData);
            doneWho.push_back(owner);
            doneErr.push_back(|oERR);
            donePulses.push_back(goPulses);
            doneLat.push_back(cyc - firstGoCyc);
            doneData.push_back(oI2C_DATA);
            doneCount++;
            if (owner >= 0) lastGntM = owner;
            owner = -1;
         end else if (oERR != '0) begin
            chk("err_without_done", oERR, 0);
         end
         prevGo   = oI2C_GO;
         prevCtrl = oI2C_CTRL_CLK;
         prevGnt  = oGNT;
      end
   end

   task automatic releaseReset(output int n);
      @(posedge iCLK); #1;
      iRST_N = 1'b1;
      n = 0;
      while (n < 40) begin
         @(posedge iCLK); #1;
         n++;
         if (oI2C_CTRL_CLK) break;
      end
   endtask

   task automatic waitDones(input int cnt, input int budget);
      int target;
      int k;
      target = doneCount + cnt;
      k = 0;
      while (doneCount < target && k < budget) begin
         @(posedge iCLK); #1;
         k++;
      end
      if (doneCount < target) chk("wait_done_timeout", doneCount, target);
   endtask

   task automatic waitHigh(input string name, input int which, input int budget);
      int k;
      k = 0;
      while (k < budget && !((which == 0) ? (oGNT != '0) : oI2C_GO)) begin
         @(posedge iCLK); #1;
         k++;
      end
      if (k >= budget) chk(name, 0, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int base;
      repeat (3) @(posedge iCLK);
      releaseReset(n);
      chk("first_ctrl_rise_after_reset", n, TICK / 2);

      // Reset in the middle of a divider count restarts it from zero.
      repeat (13) @(posedge iCLK);
      #1 iRST_N = 1'b0;
      repeat (2) @(posedge iCLK);
      releaseReset(n);
      chk("ctrl_rise_after_midcount_reset", n, TICK / 2);

      // Both requesters held: grants alternate, data sampled per grant.
      endAfter = 4; nackFirst = 0; neverEnd = 1'b0;
      iREQ_DATA[23:0]  = 24'hA1B2C3;
      iREQ_DATA[47:24] = 24'h4D5E6F;
      base = doneCount;
      iREQ = 2'b11;
      waitHigh("wait_first_grant", 0, 100);
      repeat (2) @(posedge iCLK);
      #1 iREQ_DATA[23:0] = 24'h0F0E0D;
      waitDones(4, 1000);
      iREQ = 2'b00;
      if (doneWho.size() >= base + 4) begin
         chk("alt_order_0", doneWho[base],     0);
         chk("alt_order_1", doneWho[base + 1], 1);
         chk("alt_order_2", doneWho[base + 2], 0);
         chk("alt_order_3", doneWho[base + 3], 1);
         chk("alt_data_0", doneData[base],     24'hA1B2C3);
         chk("alt_data_1", doneData[base + 1], 24'h4D5E6F);
         chk("alt_data_2", doneData[base + 2], 24'h0F0E0D);
      end

      // Single request, ACK after 5 ticks; data changes after grant ignored.
      endAfter = 5;
      iREQ_DATA[23:0] = 24'h729803;
      iREQ = 2'b01;
      waitHigh("wait_grant_a", 0, 100);
      repeat (2) @(posedge iCLK);
      #1 iREQ_DATA[23:0] = 24'h111111;
      waitDones(1, 400);
      iREQ = 2'b00;
      chk("a_who", doneWho[$], 0);
      chk("a_err", doneErr[$], 0);
      chk("a_pulses", donePulses[$], 1);
      chk("a_data", doneData[$], 24'h729803);
      chk("a_latency", doneLat[$], 41);

      // Always NACK: MAX_RETRY+1 launches then error.
      nackFirst = 100;
      iREQ = 2'b01;
      waitDones(1, 600);
      iREQ = 2'b00;
      chk("nack_pulses", donePulses[$], 4);
      chk("nack_err", doneErr[$], 1);
      chk("nack_latency", doneLat[$], 209);

      // NACK twice, then ACK.
      nackFirst = 2;
      iREQ = 2'b01;
      waitDones(1, 600);
      iREQ = 2'b00;
      chk("nack2_pulses", donePulses[$], 3);
      chk("nack2_err", doneErr[$], 0);
      chk("nack2_latency", doneLat[$], 153);

      // Controller never ends: timeout retries then error.
      nackFirst = 0;
      neverEnd = 1'b1;
      iREQ = 2'b01;
      waitDones(1, 800);
      iREQ = 2'b00;
      chk("tmo_pulses", donePulses[$], 4);
      chk("tmo_err", doneErr[$], 1);
      chk("tmo_latency", doneLat[$], 369);

      // Reset during WAIT_END: outputs drop at once, no completion reported.
      iREQ = 2'b01;
      waitHigh("wait_go_rst", 1, 200);
      repeat (3 * TICK) @(posedge iCLK);
      #3 iRST_N = 1'b0;
      iREQ = 2'b00;
      #1;
      chk("rst_mid_go", oI2C_GO, 0);
      chk("rst_mid_gnt", oGNT, 0);
      chk("rst_mid_busy", oBUSY, 0);
      base = doneCount;
      repeat (3) @(posedge iCLK);
      neverEnd = 1'b0;
      endAfter = 3;
      releaseReset(n);
      repeat (4) @(posedge iCLK);
      chk("rst_no_done", doneCount, base);

      // After reset, requester 0 wins first even though 0 was last served.
      iREQ = 2'b11;
      waitHigh("wait_grant_post_rst", 0, 100);
      chk("post_rst_first_grant", oGNT, 2'b01);
      waitDones(2, 600);
      iREQ = 2'b00;
      chk("post_rst_who_0", doneWho[base], 0);
      chk("post_rst_who_1", doneWho[base + 1], 1);

      repeat (10) @(posedge iCLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
